hazard_unit: RTL and testbench

- Pipeline hazard controller; sits beside `forward_unit` between decode (ID) and execute (EX) of the RV32IM core.
- Detects hazards that forwarding cannot cover:
  - load-use dependencies;
  - multi-cycle MUL/DIV occupancy of EX;
  - taken-branch redirects.
- Drives stall, bubble and flush controls to PC, IF/ID and ID/EX registers; only when ID is not stalled does `forward_unit` sample a valid decode instruction.

---
 rtl/hazard_unit.sv | 155 +++++++++++++++
 tb/tb_hazard_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_unit
//  Purpose  : Pipeline hazard controller between ID and EX. Detects
//             load-use dependencies, multi-cycle MUL/DIV occupancy of EX
//             and taken-branch redirects, and drives stall / bubble /
//             flush controls to the PC, IF/ID and ID/EX registers.
//  Ports    : clk, a_reset_n (async, active-low)
//             dec_*      - decoded ID instruction (valid, rs1/rs2, uses, mul/div)
//             ex_rd, ex_is_load, br_taken - EX-stage status
//             pc_stall, ifid_stall, idex_bubble, ifid_flush - pipeline controls
//             md_busy, md_done - mul/div unit occupancy and completion pulse
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_unit #(
    parameter int R          = 5,
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 32
) (
    input  logic         clk,
    input  logic         a_reset_n,
    input  logic         dec_valid,
    input  logic [R-1:0] dec_addr1,
    input  logic [R-1:0] dec_addr2,
    input  logic         useLhs,
    input  logic         useRhs,
    input  logic         useData,
    input  logic         dec_is_mul,
    input  logic         dec_is_div,
    input  logic [R-1:0] ex_rd,
    input  logic         ex_is_load,
    input  logic         br_taken,
    output logic         pc_stall,
    output logic         ifid_stall,
    output logic         idex_bubble,
    output logic         ifid_flush,
    output logic         md_busy,
    output logic         md_done
);

    // Counter is sized for the longer of the two operations so a MUL_CYCLES
    // larger than DIV_CYCLES still fits.
    localparam int C_MAX_CYC = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
    localparam int CW        = $clog2(C_MAX_CYC) + 1;

    localparam logic [CW-1:0] C_MUL_LOAD = CW'(MUL_CYCLES - 1);
    localparam logic [CW-1:0] C_DIV_LOAD = CW'(DIV_CYCLES - 1);

    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_LOAD_STALL = 2'd1;
    localparam logic [1:0] S_MD_BUSY    = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] md_cnt_q, md_cnt_d;

    logic w_lu_hit;
    logic w_md_start;

    // x0 is hard-wired zero, so a load targeting it can never create a hazard.
    assign w_lu_hit = dec_valid & ex_is_load & (ex_rd != '0) &
                      ((useLhs & (dec_addr1 == ex_rd)) |
                       ((useRhs | useData) & (dec_addr2 == ex_rd)));

    assign w_md_start = dec_valid & (dec_is_mul | dec_is_div);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            state_q  <= S_IDLE;
            md_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        case (state_q)
            S_IDLE: begin
                // A taken branch squashes the ID instruction, so neither a
                // load-use stall nor a mul/div start is allowed for it.
                if (br_taken) begin
                    state_d = S_IDLE;
                end else if (w_lu_hit) begin
                    state_d = S_LOAD_STALL;
                end else if (w_md_start) begin
                    state_d  = S_MD_BUSY;
                    md_cnt_d = dec_is_div ? C_DIV_LOAD : C_MUL_LOAD;
                end
            end
            S_LOAD_STALL: begin
                state_d = S_IDLE;
            end
            S_MD_BUSY: begin
                if (md_cnt_q != '0) begin
                    md_cnt_d = md_cnt_q - 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d  = S_IDLE;
                md_cnt_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic; everything is forced low while reset is asserted so
    // a concurrent br_taken cannot leak a flush during reset.
    // ------------------------------------------------------------------
    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        md_busy     = 1'b0;
        md_done     = 1'b0;
        if (a_reset_n) begin
            case (state_q)
                S_IDLE: begin
                    if (br_taken) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (w_lu_hit) begin
                        pc_stall    = 1'b1;
                        ifid_stall  = 1'b1;
                        idex_bubble = 1'b1;
                    end
                end
                S_MD_BUSY: begin
                    if (md_cnt_q != '0) begin
                        md_busy    = 1'b1;
                        pc_stall   = 1'b1;
                        ifid_stall = 1'b1;
                    end else begin
                        md_done = 1'b1;
                    end
                end
                default: begin
                    // LOAD_STALL: the load is in MEM and is forwarded from there.
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_unit
//  Purpose  : Self-checking bench for hazard_unit. A behavioural model tracks
//             "remaining EX occupancy" and "load bubble already taken" and is
//             compared against the DUT every cycle; directed sequences pin the
//             model with literal expectations, then randomized traffic runs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_unit;

    localparam int R          = 5;
    localparam int MUL_CYCLES = 2;
    localparam int DIV_CYCLES = 32;

    logic         clk = 1'b0;
    logic         a_reset_n;
    logic         dec_valid;
    logic [R-1:0] dec_addr1, dec_addr2;
    logic         useLhs, useRhs, useData;
    logic         dec_is_mul, dec_is_div;
    logic [R-1:0] ex_rd;
    logic         ex_is_load;
    logic         br_taken;
    logic         pc_stall, ifid_stall, idex_bubble, ifid_flush, md_busy, md_done;

    int errors = 0;
    int checks = 0;

    hazard_unit #(
        .R          (R),
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) dut (
        .clk         (clk),
        .a_reset_n   (a_reset_n),
        .dec_valid   (dec_valid),
        .dec_addr1   (dec_addr1),
        .dec_addr2   (dec_addr2),
        .useLhs      (useLhs),
        .useRhs      (useRhs),
        .useData     (useData),
        .dec_is_mul  (dec_is_mul),
        .dec_is_div  (dec_is_div),
        .ex_rd       (ex_rd),
        .ex_is_load  (ex_is_load),
        .br_taken    (br_taken),
        .pc_stall    (pc_stall),
        .ifid_stall  (ifid_stall),
        .idex_bubble (idex_bubble),
        .ifid_flush  (ifid_flush),
        .md_busy     (md_busy),
        .md_done     (md_done)
    );

    always #5 clk = ~clk;

    // Output vector order: {pc_stall, ifid_stall, idex_bubble, ifid_flush, md_busy, md_done}
    logic [5:0] outs;
    assign outs = {pc_stall, ifid_stall, idex_bubble, ifid_flush, md_busy, md_done};

    // ------------------------------------------------------------------
    // Behavioural model
    //   occ   : EX cycles still owed to a running mul/div (0 = none)
    //   lwait : the cycle after a load-use bubble, where nothing happens
    // ------------------------------------------------------------------
    int occ   = 0;
    bit lwait = 1'b0;

    function automatic bit m_lu();
        bit hit1, hit2;
        hit1 = useLhs && (dec_addr1 == ex_rd);
        hit2 = (useRhs || useData) && (dec_addr2 == ex_rd);
        return dec_valid && ex_is_load && (ex_rd != 0) && (hit1 || hit2);
    endfunction

    function automatic logic [5:0] m_expect();
        if (!a_reset_n) return 6'b000000;
        if (occ > 1)    return 6'b110010;
        if (occ == 1)   return 6'b000001;
        if (lwait)      return 6'b000000;
        if (br_taken)   return 6'b001100;
        if (m_lu())     return 6'b111000;
        return 6'b000000;
    endfunction

    always @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            occ   <= 0;
            lwait <= 1'b0;
        end else if (occ > 0) begin
            occ <= occ - 1;
        end else if (lwait) begin
            lwait <= 1'b0;
        end else if (br_taken) begin
            occ <= 0;
        end else if (m_lu()) begin
            lwait <= 1'b1;
        end else if (dec_valid && (dec_is_mul || dec_is_div)) begin
            occ <= dec_is_div ? DIV_CYCLES : MUL_CYCLES;
        end
    end

    // Continuous compare against the model, mid-cycle.
    always @(negedge clk) begin
        logic [5:0] e;
        e = m_expect();
        checks = checks + 1;
        if (outs !== e) begin
            errors = errors + 1;
            $display("FAIL model_cmp t=%0t got=%b exp=%b", $time, outs, e);
        end
    end

    // ------------------------------------------------------------------
    // Directed helpers
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [5:0] exp);
        checks = checks + 1;
        if (outs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s t=%0t got=%b exp=%b", name, $time, outs, exp);
        end
    endtask

    task automatic quiet();
        dec_valid  = 1'b0;
        dec_addr1  = '0;
        dec_addr2  = '0;
        useLhs     = 1'b0;
        useRhs     = 1'b0;
        useData    = 1'b0;
        dec_is_mul = 1'b0;
        dec_is_div = 1'b0;
        ex_rd      = '0;
        ex_is_load = 1'b0;
        br_taken   = 1'b0;
    endtask

    // Advance to just after the next rising edge.
    task automatic go();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_reset_n = 1'b0;
        quiet();
        br_taken = 1'b1;           // must not leak a flush during reset
        #2;
        chk("reset_outs", 6'b000000);
        go(); go();
        #2 a_reset_n = 1'b1;
        br_taken = 1'b0;

        // ---- load-use via rs1 ----
        go();
        dec_valid = 1; ex_is_load = 1; ex_rd = 5; dec_addr1 = 5; useLhs = 1;
        #1 chk("lu_rs1_stall", 6'b111000);
        go();
        #1 chk("lu_rs1_loadstall", 6'b000000);
        go();
        ex_rd = 0; dec_addr1 = 0;
        #1 chk("lu_x0_none", 6'b000000);

        // ---- load-use via store data ----
        go();
        quiet();
        dec_valid = 1; ex_is_load = 1; ex_rd = 7; dec_addr2 = 7; useData = 1;
        #1 chk("lu_data_stall", 6'b111000);
        go();
        #1 chk("lu_data_loadstall", 6'b000000);
        go();
        dec_addr2 = 8;
        #1 chk("lu_data_miss", 6'b000000);

        // ---- branch beats load-use and mul start ----
        go();
        quiet();
        dec_valid = 1; ex_is_load = 1; ex_rd = 3; dec_addr1 = 3; useLhs = 1;
        dec_is_mul = 1; br_taken = 1;
        #1 chk("br_priority", 6'b001100);
        go();
        quiet();
        #1 chk("br_no_mul", 6'b000000);

        // ---- divide: 31 busy cycles then done; ignored events inside ----
        go();
        dec_valid = 1; dec_is_div = 1;
        #1 chk("div_issue", 6'b000000);
        for (int i = 0; i < DIV_CYCLES - 1; i++) begin
            go();
            quiet();
            if (i % 3 == 1) br_taken = 1;
            if (i % 4 == 2) begin
                dec_valid = 1; ex_is_load = 1; ex_rd = 9; dec_addr1 = 9; useLhs = 1;
                dec_is_mul = 1;
            end
            #1 chk("div_busy", 6'b110010);
        end
        go();
        quiet();
        #1 chk("div_done", 6'b000001);
        go();
        #1 chk("div_after", 6'b000000);

        // ---- multiply ----
        go();
        dec_valid = 1; dec_is_mul = 1;
        #1 chk("mul_issue", 6'b000000);
        go();
        quiet();
        #1 chk("mul_busy", 6'b110010);
        go();
        #1 chk("mul_done", 6'b000001);

        // ---- reset in the middle of a divide ----
        go();
        dec_valid = 1; dec_is_div = 1;
        for (int i = 0; i < 10; i++) begin
            go();
            quiet();
        end
        #1 chk("div_busy_pre_rst", 6'b110010);
        #1 a_reset_n = 1'b0;
        #1 chk("rst_async", 6'b000000);
        go();
        #2 a_reset_n = 1'b1;
        #1 chk("rst_release", 6'b000000);
        go();
        dec_valid = 1; dec_is_mul = 1;
        go();
        quiet();
        #1 chk("rst_mul_busy", 6'b110010);
        go();
        #1 chk("rst_mul_done", 6'b000001);
        go();
        #1 chk("rst_no_stale", 6'b000000);

        // ---- randomized traffic against the model ----
        for (int n = 0; n < 3000; n++) begin
            go();
            a_reset_n  = ($urandom_range(0, 249) != 0);
            dec_valid  = ($urandom_range(0, 9) < 8);
            dec_addr1  = R'($urandom_range(0, 3));
            dec_addr2  = R'($urandom_range(0, 3));
            useLhs     = $urandom_range(0, 1);
            useRhs     = $urandom_range(0, 1);
            useData    = $urandom_range(0, 1);
            dec_is_mul = ($urandom_range(0, 9) == 0);
            dec_is_div = ($urandom_range(0, 24) == 0);
            ex_rd      = R'($urandom_range(0, 3));
            ex_is_load = $urandom_range(0, 1);
            br_taken   = ($urandom_range(0, 6) == 0);
        end
        go();
        a_reset_n = 1'b1;
        quiet();
        repeat (40) go();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
